fdiv32: RTL and testbench

Iterative single-precision IEEE-754 divider, the inverse-direction companion of the pipelined FP32 multiplier in the same arithmetic cluster. It accepts `op1 / op2` with a start pulse, runs a radix-2 restoring mantissa division over multiple cycles, rounds per `r_mode`, and presents `result` with a one-cycle `val` pulse. It is unpipelined: one operation in flight, with `ready` gating new starts.

---
 rtl/fp32_pkg.sv | 63 ++++++
 rtl/fdiv32_round.sv | 57 +++++
 rtl/fdiv32.sv | 157 +++++++++++++++
 tb/tb_fdiv32.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: FP32 constants, rounding modes, operand layout and divider FSM encodings.
// FDIV32_DENORM_EN adds the NORM state and turns on gradual underflow.
package fp32_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rmode_t;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam logic [31:0] MAXF    = 32'h7F7F_FFFF;

`ifdef FDIV32_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_DIV   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`else
    localparam bit DENORM_EN = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV   = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`endif

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Leading-zero count of a 24-bit significand (24 when all zero).
    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (m[i]) n = 5'(23 - i);
        return n;
    endfunction

    // Overflow saturates to inf only when the mode rounds away from zero.
    function automatic logic [31:0] ovf_value(input logic s, input rmode_t m);
        logic away;
        case (m)
            RM_RNE:  away = 1'b1;
            RM_RTZ:  away = 1'b0;
            RM_RUP:  away = ~s;
            default: away = s;
        endcase
        return away ? {s, EXP_INF, 23'd0} : {s, MAXF[30:0]};
    endfunction

endpackage

// File: rtl/fdiv32_round.sv
// fdiv32_round: normalizes the raw quotient, rounds per mode, flags overflow/underflow.
// With FDIV32_DENORM_EN, underflowed results are denormalized (sticky kept) before rounding.
module fdiv32_round
    import fp32_pkg::*;
#(
    parameter int QUOT_W = 26
) (
    input  logic               sign,
    input  logic signed [9:0]  e,
    input  logic [QUOT_W-1:0]  q,
    input  logic               sticky,
    input  rmode_t             mode,
    output logic [31:0]        res,
    output logic               ovf,
    output logic               unf
);
    logic [QUOT_W-1:0] nq;
    logic signed [9:0] en, ef;
    logic [25:0]       ext;
    logic [23:0]       m;
    logic [24:0]       mr;
    logic              g, r, st, inc;
`ifdef FDIV32_DENORM_EN
    logic signed [9:0] shw;
    logic [4:0]        sh;
`endif

    always_comb begin
        nq  = q[QUOT_W-1] ? q : (q << 1);
        en  = q[QUOT_W-1] ? e : (e - 10'sd1);
        unf = (en <= 10'sd0);
        ext = nq[QUOT_W-1 -: 26];
        st  = sticky;
`ifdef FDIV32_DENORM_EN
        shw = 10'sd1 - en;
        sh  = '0;
        if (unf) sh = (shw > 10'sd26) ? 5'd26 : shw[4:0];
        st  = st | ((ext & ((26'd1 << sh) - 26'd1)) != '0);
        ext = ext >> sh;
`endif
        m = ext[25:2];
        g = ext[1];
        r = ext[0];
        case (mode)
            RM_RNE:  inc = g & (r | st | m[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | r | st);
            default: inc = sign & (g | r | st);
        endcase
        mr  = {1'b0, m} + 25'(inc);
        ef  = mr[24] ? (en + 10'sd1) : en;
        ovf = ~unf & (ef >= 10'sd255);
        // A denormal that rounds up into bit 23 lands naturally on exponent field 1.
        res = unf ? {sign, 7'd0, mr[23:0]} : {sign, ef[7:0], mr[22:0]};
    end

endmodule

// File: rtl/fdiv32.sv
// fdiv32: iterative FP32 divider, radix-2 restoring, one operation in flight.
// Define FDIV32_DENORM_EN for denormal inputs (NORM state) and gradual underflow.
module fdiv32
    import fp32_pkg::*;
#(
    parameter int QUOT_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [1:0]  r_mode,
    output logic        ready,
    output logic [31:0] result,
    output logic        val
);
    localparam int CNT_W = $clog2(QUOT_W);

    state_t            state;
    fp32_t             a, b;
    rmode_t            mode;
    logic              sign;
    logic [23:0]       ma, mb;
    logic signed [9:0] e;
    logic [24:0]       rem;
    logic [QUOT_W-1:0] q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       res_r, sp_res, rnd_res;
    logic [25:0]       diff;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
    logic              rnd_ovf, rnd_unf;
`ifdef FDIV32_DENORM_EN
    logic signed [9:0] ea, eb, ea_n, eb_n;
    logic [23:0]       ma_n, mb_n;
    logic [4:0]        lza, lzb;
    logic              need_norm;
`endif

    assign a = op1;
    assign b = op2;

    always_comb begin
        a_nan  = (a.exp == EXP_INF) && (a.frac != '0);
        b_nan  = (b.exp == EXP_INF) && (b.frac != '0);
        a_inf  = (a.exp == EXP_INF) && (a.frac == '0);
        b_inf  = (b.exp == EXP_INF) && (b.frac == '0);
`ifdef FDIV32_DENORM_EN
        a_zero = (a.exp == '0) && (a.frac == '0);
        b_zero = (b.exp == '0) && (b.frac == '0);
`else
        a_zero = (a.exp == '0);
        b_zero = (b.exp == '0);
`endif
        is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        sp_res = {a.sign ^ b.sign, 31'd0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            sp_res = QNAN;
        else if (a_inf || b_zero)
            sp_res = {a.sign ^ b.sign, EXP_INF, 23'd0};
        // Compare-then-shift form of r = 2r - mB: the first bit is mA >= mB.
        diff = {1'b0, rem} - {2'b00, mb};
    end

`ifdef FDIV32_DENORM_EN
    always_comb begin
        need_norm = (a.exp == '0) || (b.exp == '0);
        lza  = lzc24(ma);
        lzb  = lzc24(mb);
        ma_n = ma << lza;
        mb_n = mb << lzb;
        ea_n = ma[23] ? ea : (10'sd1 - $signed({5'd0, lza}));
        eb_n = mb[23] ? eb : (10'sd1 - $signed({5'd0, lzb}));
    end
`endif

    fdiv32_round #(.QUOT_W(QUOT_W)) u_round (
        .sign   (sign),
        .e      (e),
        .q      (q),
        .sticky (rem != '0),
        .mode   (mode),
        .res    (rnd_res),
        .ovf    (rnd_ovf),
        .unf    (rnd_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            val    <= 1'b0;
            result <= '0;
            res_r  <= '0;
        end else begin
            val <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    ready <= 1'b0;
                    sign  <= a.sign ^ b.sign;
                    mode  <= rmode_t'(r_mode);
                    ma    <= {a.exp != '0, a.frac};
                    mb    <= {b.exp != '0, b.frac};
                    rem   <= {1'b0, a.exp != '0, a.frac};
                    e     <= $signed({2'b00, a.exp}) - $signed({2'b00, b.exp}) + 10'(BIAS);
                    q     <= '0;
                    cnt   <= '0;
`ifdef FDIV32_DENORM_EN
                    ea    <= $signed({2'b00, a.exp});
                    eb    <= $signed({2'b00, b.exp});
`endif
                    if (is_special) begin
                        res_r <= sp_res;
                        state <= ST_DONE;
                    end
`ifdef FDIV32_DENORM_EN
                    else if (need_norm)
                        state <= ST_NORM;
`endif
                    else
                        state <= ST_DIV;
                end
`ifdef FDIV32_DENORM_EN
                ST_NORM: begin
                    ma    <= ma_n;
                    mb    <= mb_n;
                    rem   <= {1'b0, ma_n};
                    e     <= ea_n - eb_n + 10'(BIAS);
                    state <= ST_DIV;
                end
`endif
                ST_DIV: begin
                    q   <= {q[QUOT_W-2:0], ~diff[25]};
                    rem <= diff[25] ? (rem << 1) : (diff[24:0] << 1);
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(QUOT_W - 1)) state <= ST_ROUND;
                end
                ST_ROUND: begin
                    res_r <= rnd_ovf ? ovf_value(sign, mode) :
                             (rnd_unf && !DENORM_EN) ? {sign, 31'd0} : rnd_res;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    result <= res_r;
                    val    <= 1'b1;
                    ready  <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv32.sv
// tb_fdiv32: directed and random checks of fdiv32 against an exact integer-quotient model.
// Follows FDIV32_DENORM_EN so the model and latencies match the build.
module tb_fdiv32;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [1:0]  r_mode = '0;
    logic        ready, val;
    logic [31:0] result;

    int          cyc = 0, checks = 0, fails = 0;
    bit          pend = 0;
    int          t0 = 0, exp_cyc = 0;
    logic [31:0] exp_res = '0;

`ifdef FDIV32_DENORM_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    fdiv32 #(.QUOT_W(26)) dut (
        .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
        .r_mode(r_mode), .ready(ready), .result(result), .val(val)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 0;
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:23] == 0 && (x[22:0] == 0 || !DEN);
    endfunction
    function automatic bit special(input logic [31:0] x, input logic [31:0] y);
        return is_nan(x) || is_nan(y) || is_inf(x) || is_inf(y) || is_zero(x) || is_zero(y);
    endfunction

    // Exact quotient of integer significands, rounded to FP32 from first principles.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        logic         s, g, st, inc, away;
        logic [127:0] num, qt, kept, mask;
        logic [23:0]  mx, my;
        int           xa, xb, sc, p, bexp, sh;
        s = x[31] ^ y[31];
        if (is_nan(x) || is_nan(y) || (is_zero(x) && is_zero(y)) || (is_inf(x) && is_inf(y)))
            return 32'h7FC00000;
        if (is_inf(x) || is_zero(y)) return {s, 31'h7F800000};
        if (is_zero(x) || is_inf(y)) return {s, 31'd0};
        mx = {x[30:23] != 0, x[22:0]};
        my = {y[30:23] != 0, y[22:0]};
        xa = ((x[30:23] == 0) ? 1 : int'(x[30:23])) - 150;
        xb = ((y[30:23] == 0) ? 1 : int'(y[30:23])) - 150;
        num = 128'(mx) << 64;
        qt  = num / 128'(my);
        st  = (num % 128'(my)) != 0;
        sc  = xa - xb - 64;
        p   = 0;
        for (int i = 0; i < 128; i++) if (qt[i]) p = i;
        bexp = p + sc + 127;
        if (bexp <= 0) begin
            if (!DEN) return {s, 31'd0};
            sh = -149 - sc;
        end else sh = p - 23;
        if (sh > 120) begin
            kept = 0; g = 0; st = 1;
        end else begin
            kept = qt >> sh;
            g    = qt[sh-1];
            mask = (128'd1 << (sh - 1)) - 1;
            st   = st | ((qt & mask) != 0);
        end
        case (m)
            2'd0:    inc = g & (st | kept[0]);
            2'd1:    inc = 0;
            2'd2:    inc = !s & (g | st);
            default: inc = s & (g | st);
        endcase
        kept = kept + 128'(inc);
        if (bexp <= 0) return {s, kept[30:0]};
        if (kept == (128'd1 << 24)) begin
            kept = kept >> 1;
            bexp++;
        end
        if (bexp >= 255) begin
            away = (m == 2'd0) || (m == 2'd2 && !s) || (m == 2'd3 && s);
            return away ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
        end
        return {s, 8'(bexp), kept[22:0]};
    endfunction

    function automatic int lat(input logic [31:0] x, input logic [31:0] y);
        if (special(x, y)) return 1;
        if (DEN && (x[30:23] == 0 || y[30:23] == 0)) return 29;
        return 28;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0]  ex;
        logic [22:0] fr;
        fr = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       ex = 8'd0;
            1:       ex = 8'hFF;
            2:       ex = 8'($urandom_range(1, 12));
            3:       ex = 8'($urandom_range(240, 254));
            default: ex = 8'($urandom_range(96, 160));
        endcase
        case ($urandom_range(0, 7))
            0:       fr = '0;
            1:       fr = '1;
            default: ;
        endcase
        return {1'($urandom), ex, fr};
    endfunction

    // Single compare process: val timing, result value, ready while busy.
    always @(negedge clk) begin
        if (rst) begin
            if (val) chk("val_during_rst", 32'(val), 32'd0);
        end else if (pend && cyc == exp_cyc) begin
            chk("val_at_latency", 32'(val), 32'd1);
            chk("result", result, exp_res);
            chk("ready_with_val", 32'(ready), 32'd1);
            pend = 0;
        end else begin
            if (val) chk("spurious_val", 32'(val), 32'd0);
            if (pend && cyc >= t0) chk("ready_busy", 32'(ready), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        op1 = x; op2 = y; r_mode = m; start = 1'b1;
        t0      = cyc + 1;
        exp_cyc = t0 + lat(x, y);
        exp_res = model(x, y, m);
        pend    = 1;
        tick();
        start = 1'b0; op1 = $urandom; op2 = $urandom; r_mode = 2'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64 && pend; i++) tick();
        if (pend) begin
            checks++; fails++;
            $display("FAIL timeout: no val by cycle %0d, wanted at %0d", cyc, exp_cyc);
            pend = 0;
        end
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        launch(x, y, m);
        wait_done();
    endtask

    initial begin
        // Pin the model to hand-derived results.
        chk("m_6div2",     model(32'h40C00000, 32'h40000000, 2'd0), 32'h40400000);
        chk("m_third_rne", model(32'h3F800000, 32'h40400000, 2'd0), 32'h3EAAAAAB);
        chk("m_third_rtz", model(32'h3F800000, 32'h40400000, 2'd1), 32'h3EAAAAAA);
        chk("m_third_rup", model(32'h3F800000, 32'h40400000, 2'd2), 32'h3EAAAAAB);
        chk("m_third_rdn", model(32'h3F800000, 32'h40400000, 2'd3), 32'h3EAAAAAA);
        chk("m_div0",      model(32'h3F800000, 32'h00000000, 2'd0), 32'h7F800000);
        chk("m_0div0",     model(32'h00000000, 32'h00000000, 2'd0), 32'h7FC00000);
        chk("m_ndivinf",   model(32'hBF800000, 32'h7F800000, 2'd0), 32'h80000000);
        chk("m_ovf_rne",   model(32'h7F7FFFFF, 32'h3E800000, 2'd0), 32'h7F800000);
        chk("m_ovf_rtz",   model(32'h7F7FFFFF, 32'h3E800000, 2'd1), 32'h7F7FFFFF);
        chk("m_ovf_rdn",   model(32'hFF7FFFFF, 32'h3E800000, 2'd3), 32'hFF800000);
        chk("m_denorm",    model(32'h00000001, 32'h3F800000, 2'd0), DEN ? 32'h00000001 : 32'h00000000);
        chk("m_lat_den",   32'(lat(32'h00000001, 32'h3F800000)), DEN ? 32'd29 : 32'd1);

        repeat (3) tick();
        chk("rst_result", result, 32'd0);
        chk("rst_val",    32'(val), 32'd0);
        chk("rst_ready",  32'(ready), 32'd1);
        rst = 1'b0;
        tick();

        run(32'h40C00000, 32'h40000000, 2'd0);
        for (int m = 0; m < 4; m++) run(32'h3F800000, 32'h40400000, 2'(m));
        run(32'h3F800000, 32'h00000000, 2'd0);
        run(32'h00000000, 32'h00000000, 2'd0);
        run(32'hBF800000, 32'h7F800000, 2'd0);
        run(32'h7F7FFFFF, 32'h3E800000, 2'd0);
        run(32'h7F7FFFFF, 32'h3E800000, 2'd1);
        run(32'hFF7FFFFF, 32'h3E800000, 2'd3);
        run(32'h00000001, 32'h3F800000, 2'd0);

        // A start while busy must leave the in-flight operation untouched.
        launch(32'h40C00000, 32'h40000000, 2'd0);
        while (cyc < t0 + 4) tick();
        op1 = 32'h3F800000; op2 = 32'h40400000; r_mode = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();

        // Reset mid-operation: no val, idle outputs, then a clean restart.
        launch(32'h3F800000, 32'h40400000, 2'd0);
        while (cyc < t0 + 9) tick();
        rst = 1'b1;
        pend = 0;
        tick();
        chk("abort_ready",  32'(ready), 32'd1);
        chk("abort_result", result, 32'd0);
        chk("abort_val",    32'(val), 32'd0);
        rst = 1'b0;
        tick();
        run(32'h40C00000, 32'h40000000, 2'd0);

        for (int i = 0; i < 250; i++) run(rnd_fp(), rnd_fp(), 2'($urandom));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
